// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with ROB-tagged single-cycle result pulse.
// Define MUL_DIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module mul_div_unit #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [XLEN-1:0]      in_val1,
    input  logic [XLEN-1:0]      in_val2,
    input  logic [ROB_WIDTH-1:0] in_rob_index,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_res,
    output logic [ROB_WIDTH-1:0] out_rob_index
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             op_r;
    logic [ROB_WIDTH-1:0]   tag_r;
    logic                   sign1_r, sign2_r;
    logic [XLEN-1:0]        hi_r, lo_r, b_r;
    logic                   out_valid_r;
    logic [XLEN-1:0]        out_res_r;
    logic [ROB_WIDTH-1:0]   out_rob_r;

    logic                   accept, fire;
    logic [XLEN-1:0]        done_res;

    function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Operand conditioning at accept: magnitudes plus sign flags.
    logic            rs1_signed, rs2_signed, sg1, sg2;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf, special;

    assign rs1_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
    assign rs2_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    assign sg1        = rs1_signed & in_val1[XLEN-1];
    assign sg2        = rs2_signed & in_val2[XLEN-1];
    assign a_abs      = cond_neg_x(in_val1, sg1);
    assign b_abs      = cond_neg_x(in_val2, sg2);
    assign div_zero   = in_op[2] && (in_val2 == '0);
    assign div_ovf    = in_op[2] && !in_op[0] && (in_val1 == MOST_NEG) && (&in_val2);
    assign special    = div_zero || div_ovf;

`ifdef MUL_DIV_FAST_MUL_EN
    // Sign-extend to 2*XLEN so the low 2*XLEN bits of the product are exact for every variant.
    logic signed [2*XLEN-1:0] fm_a, fm_b, fm_prod;
    assign fm_a    = {{XLEN{rs1_signed & in_val1[XLEN-1]}}, in_val1};
    assign fm_b    = {{XLEN{rs2_signed & in_val2[XLEN-1]}}, in_val2};
    assign fm_prod = fm_a * fm_b;
`endif

    logic [XLEN:0] mul_sum, div_shift, div_diff;
    assign mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    assign div_shift = {hi_r, lo_r[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_r};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nxt = S_DONE;
                    end else if (in_op[2]) begin
                        state_nxt = S_DIV;
                    end else begin
`ifdef MUL_DIV_FAST_MUL_EN
                        state_nxt = S_DONE;
`else
                        state_nxt = S_MUL;
`endif
                    end
                end
            end
            S_MUL, S_DIV: if (cnt == LAST_ITER) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
        if (!rdy_in) state_nxt = state;
        if (flush)   state_nxt = S_IDLE;
    end

    always_comb begin
        logic [2*XLEN-1:0] full;
        in_ready = (state == S_IDLE) && !out_valid_r && !rst_in;
        accept   = rdy_in && in_valid && in_ready && !flush;
        fire     = (state == S_DONE) && rdy_in && !flush;
        full     = cond_neg_2x({hi_r, lo_r}, sign1_r ^ sign2_r);
        if (!op_r[2]) begin
            done_res = (op_r[1:0] == 2'd0) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        end else if (!op_r[1]) begin
            done_res = cond_neg_x(lo_r, sign1_r ^ sign2_r);
        end else begin
            done_res = cond_neg_x(hi_r, sign1_r);
        end
    end

    // Iteration datapath: hi/lo form the product register or the remainder/quotient pair.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt     <= '0;
            op_r    <= '0;
            tag_r   <= '0;
            sign1_r <= 1'b0;
            sign2_r <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            b_r     <= '0;
        end else if (rdy_in && !flush) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r  <= in_op;
                        tag_r <= in_rob_index;
                        cnt   <= '0;
                        b_r   <= b_abs;
                        if (special) begin
                            sign1_r <= 1'b0;
                            sign2_r <= 1'b0;
                            hi_r    <= div_zero ? in_val1 : '0;
                            lo_r    <= div_zero ? '1 : in_val1;
`ifdef MUL_DIV_FAST_MUL_EN
                        end else if (!in_op[2]) begin
                            sign1_r <= 1'b0;
                            sign2_r <= 1'b0;
                            hi_r    <= fm_prod[2*XLEN-1:XLEN];
                            lo_r    <= fm_prod[XLEN-1:0];
`endif
                        end else begin
                            sign1_r <= sg1;
                            sign2_r <= sg2;
                            hi_r    <= '0;
                            lo_r    <= a_abs;
                        end
                    end
                end
                S_MUL: begin
                    hi_r <= mul_sum[XLEN:1];
                    lo_r <= {mul_sum[0], lo_r[XLEN-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    if (!div_diff[XLEN]) begin
                        hi_r <= div_diff[XLEN-1:0];
                        lo_r <= {lo_r[XLEN-2:0], 1'b1};
                    end else begin
                        hi_r <= div_shift[XLEN-1:0];
                        lo_r <= {lo_r[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result pulse: cleared every edge so a stall can only delay it, never repeat it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid_r <= 1'b0;
            out_res_r   <= '0;
            out_rob_r   <= '0;
        end else begin
            out_valid_r <= fire;
            if (fire) begin
                out_res_r <= done_res;
                out_rob_r <= tag_r;
            end
        end
    end

    assign out_valid     = out_valid_r && !flush;
    assign out_res       = out_res_r;
    assign out_rob_index = out_rob_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush, stall and reset sequences.
module tb_mul_div_unit;

    localparam int XLEN = 32;
    localparam int RW   = 6;
`ifdef MUL_DIV_FAST_MUL_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = 33;
`endif

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, flush, in_valid, in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_val1, in_val2, out_res;
    logic [RW-1:0]   in_rob_index, out_rob_index;
    logic            out_valid;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(XLEN), .ROB_WIDTH(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_val1(in_val1), .in_val2(in_val2), .in_rob_index(in_rob_index),
        .out_valid(out_valid), .out_res(out_res), .out_rob_index(out_rob_index)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk_in); #1;
            w++;
        end
        chk("issue_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_op = op; in_val1 = a; in_val2 = b; in_rob_index = tag;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int stall_at, input int stall_len, output int lat);
        lat = 0;
        if (stall_len > 0 && stall_at == 0) rdy_in = 1'b0;
        while (lat < 100) begin
            @(posedge clk_in); #1;
            lat++;
            if (stall_len > 0 && lat == stall_at + stall_len) rdy_in = 1'b1;
            else if (stall_len > 0 && lat == stall_at) rdy_in = 1'b0;
            if (out_valid) break;
        end
        rdy_in = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tag, input logic [31:0] res,
                          input int lat, input int stall_at, input int stall_len);
        int got_lat;
        issue(op, a, b, tag);
        wait_result(stall_at, stall_len, got_lat);
        chk({name, "_lat"}, got_lat, lat);
        chk({name, "_res"}, out_res, res);
        chk({name, "_tag"}, {26'd0, out_rob_index}, {26'd0, tag});
        @(posedge clk_in); #1;
        chk({name, "_single_pulse"}, out_valid, 1'b0);
        chk({name, "_ready_after"}, in_ready, 1'b1);
        chk({name, "_res_hold"}, out_res, res);
    endtask

    task automatic watch_no_pulse(input string name, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            if (out_valid) seen = 1'b1;
        end
        chk(name, seen, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{"mul",        3'd0, 32'd7,        32'hFFFFFFFD, 6'h2A, 32'hFFFFFFEB, MLAT};
        vecs[1]  = '{"mulh",       3'd1, 32'h80000000, 32'h80000000, 6'h01, 32'h40000000, MLAT};
        vecs[2]  = '{"mulhsu",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h02, 32'hFFFFFFFF, MLAT};
        vecs[3]  = '{"mulhu",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h03, 32'hFFFFFFFE, MLAT};
        vecs[4]  = '{"mulh_neg",   3'd1, 32'hFFFFFFFF, 32'd1,        6'h04, 32'hFFFFFFFF, MLAT};
        vecs[5]  = '{"div",        3'd4, 32'hFFFFFFF9, 32'd2,        6'h05, 32'hFFFFFFFD, 33};
        vecs[6]  = '{"rem",        3'd6, 32'hFFFFFFF9, 32'd2,        6'h06, 32'hFFFFFFFF, 33};
        vecs[7]  = '{"divu",       3'd5, 32'd100,      32'd7,        6'h07, 32'd14,       33};
        vecs[8]  = '{"remu",       3'd7, 32'd100,      32'd7,        6'h08, 32'd2,        33};
        vecs[9]  = '{"div_zero",   3'd4, 32'd5,        32'd0,        6'h09, 32'hFFFFFFFF, 1};
        vecs[10] = '{"rem_zero",   3'd6, 32'd5,        32'd0,        6'h0A, 32'd5,        1};
        vecs[11] = '{"div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 6'h0B, 32'h80000000, 1};
        vecs[12] = '{"rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 6'h0C, 32'd0,        1};
        vecs[13] = '{"remu_zero",  3'd7, 32'd9,        32'd0,        6'h0D, 32'd9,        1};

        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_val1 = '0; in_val2 = '0; in_rob_index = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready_low", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_tag", {26'd0, out_rob_index}, 32'd0);
        rst_in = 1'b0;
        #1;
        chk("rst_release_ready", in_ready, 1'b1);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                   vecs[i].res, vecs[i].lat, 0, 0);
        end

        // Stall mid-divide: five held edges push the pulse from 33 to 38.
        run_op("div_stall", 3'd5, 32'd100, 32'd7, 6'h15, 32'd14, 38, 10, 5);
        // Stall while a special-case result is pending: delayed by three, emitted once.
        run_op("done_stall", 3'd4, 32'd5, 32'd0, 6'h16, 32'hFFFFFFFF, 4, 0, 3);

        // Flush ten cycles into a divide.
        issue(3'd4, 32'd1000, 32'd3, 6'h11);
        repeat (10) begin @(posedge clk_in); #1; end
        flush = 1'b1;
        #1;
        chk("flush_valid_low", out_valid, 1'b0);
        @(posedge clk_in); #1;
        flush = 1'b0;
        chk("flush_ready_next", in_ready, 1'b1);
        watch_no_pulse("flush_no_pulse", 40);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 6'h12, 32'd12, MLAT, 0, 0);

        // Flush coinciding with a result pulse masks it combinationally.
        issue(3'd5, 32'd5, 32'd0, 6'h17);
        @(posedge clk_in); #1;
        chk("pulse_before_flush", out_valid, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_masks_pulse", out_valid, 1'b0);
        @(posedge clk_in); #1;
        flush = 1'b0;

        // Reset mid-multiply.
        issue(3'd0, 32'd3, 32'd4, 6'h13);
        repeat (10) begin @(posedge clk_in); #1; end
        rst_in = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_res", out_res, 32'd0);
        chk("midrst_tag", {26'd0, out_rob_index}, 32'd0);
        chk("midrst_ready_low", in_ready, 1'b0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        chk("midrst_ready_after", in_ready, 1'b1);
        watch_no_pulse("midrst_no_pulse", 40);
        run_op("mul_after_rst", 3'd0, 32'd6, 32'd7, 6'h14, 32'd42, MLAT, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
